// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   pc_t          : 32-bit byte address
//   fetch_state_t : fetch FSM state (FETCH, LAST, DONE)
//   align_word()  : clears the two byte-offset bits of an address
package instruction_fetch_stage_pkg;

  typedef logic [31:0] pc_t;

  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LAST  = 2'd1,
    DONE  = 2'd2
  } fetch_state_t;

  function automatic pc_t align_word(input pc_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Bundle of every signal between the fetch stage and its neighbours
// (hazard unit, Execute redirect, instruction ROM, Decode).
//   master : the fetch stage itself
//   slave  : the surrounding pipeline / testbench
//
// Handshake: there is no ready signal. instr_D/pc_plus4_D carry a real
// instruction only while valid_D=1; Decode back-pressures with stall_D
// (IF/ID holds) and the PC with stall_F (PC holds). flush_D always wins
// over stall_D and turns the IF/ID slot into a bubble. A redirect
// (pc_src_E) is taken on the edge it is seen, regardless of stall_F.
interface instruction_fetch_stage_if;
  import instruction_fetch_stage_pkg::*;

  logic         stall_F;
  logic         stall_D;
  logic         flush_D;
  logic         pc_src_E;
  pc_t          pc_target_E;
  pc_t          imem_addr;
  logic [31:0]  imem_rd;
  logic [31:0]  instr_D;
  pc_t          pc_plus4_D;
  logic         valid_D;
  logic         misalign;
  logic         done;
  logic [31:0]  fetch_count;
  fetch_state_t state;  // debug view of the fetch FSM

  modport master (
    input  stall_F, stall_D, flush_D, pc_src_E, pc_target_E, imem_rd,
    output imem_addr, instr_D, pc_plus4_D, valid_D, misalign, done,
           fetch_count, state
  );

  modport slave (
    output stall_F, stall_D, flush_D, pc_src_E, pc_target_E, imem_rd,
    input  imem_addr, instr_D, pc_plus4_D, valid_D, misalign, done,
           fetch_count, state
  );

endinterface

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register.
//   flush       : force a bubble (beats stall)
//   stall       : hold all outputs
//   fetch_valid : the word presented is a real fetch; otherwise a bubble
//                 is loaded
//   instr_in / pc_plus4_in : word and PC+4 captured on a load
//   instr / pc_plus4 / valid : registered outputs to Decode
module instruction_fetch_stage_if_id_register
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] BUBBLE = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  input  logic        fetch_valid,
  input  logic [31:0] instr_in,
  input  pc_t         pc_plus4_in,
  output logic [31:0] instr,
  output pc_t         pc_plus4,
  output logic        valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr    <= BUBBLE;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush || (!stall && !fetch_valid)) begin
      instr    <= BUBBLE;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (!stall) begin
      instr    <= instr_in;
      pc_plus4 <= pc_plus4_in;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, addresses the instruction ROM (zero latency)
// and captures the returned word into IF/ID.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   fif        : master side of instruction_fetch_stage_if
// The FSM walks FETCH -> LAST -> DONE once the last ROM word has been
// loaded; the PC never wraps back to 0. Only a redirect restarts fetching.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter pc_t         RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 128,
  parameter logic [31:0] NOP_INSTR  = instruction_fetch_stage_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_stage_if.master fif
);

  localparam pc_t LAST_PC = pc_t'((IMEM_DEPTH - 1) * WORD_BYTES);
  localparam pc_t PC_STEP = pc_t'(WORD_BYTES);

  pc_t          pc_f;
  fetch_state_t state;
  logic         done_r;
  logic         misalign_r;
  logic [31:0]  fetch_count_r;
  pc_t          target_aligned;
  logic         counted_load;

  logic [31:0]  instr_q;
  pc_t          pc_plus4_q;
  logic         valid_q;

  assign target_aligned  = align_word(fif.pc_target_E);
  // A real instruction enters IF/ID only on an unflushed, unstalled edge
  // while still fetching.
  assign counted_load    = !fif.flush_D && !fif.stall_D && (state == FETCH);

  assign fif.imem_addr   = pc_f;
  assign fif.done        = done_r;
  assign fif.misalign    = misalign_r;
  assign fif.fetch_count = fetch_count_r;
  assign fif.state       = state;
  assign fif.instr_D     = instr_q;
  assign fif.pc_plus4_D  = pc_plus4_q;
  assign fif.valid_D     = valid_q;

  // PC and FSM. Redirect beats stall_F; a target past the ROM is taken
  // but goes straight to DONE since nothing there can be fetched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f       <= RESET_PC;
      state      <= FETCH;
      done_r     <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= fif.pc_src_E && (fif.pc_target_E[1:0] != 2'b00);
      if (fif.pc_src_E) begin
        pc_f <= target_aligned;
        if (target_aligned > LAST_PC) begin
          state  <= DONE;
          done_r <= 1'b1;
        end else begin
          state  <= FETCH;
          done_r <= 1'b0;
        end
      end else if (!fif.stall_F) begin
        case (state)
          FETCH: begin
            if (pc_f == LAST_PC) state <= LAST;
            else                 pc_f  <= pc_f + PC_STEP;
          end
          LAST: begin
            state  <= DONE;
            done_r <= 1'b1;
          end
          DONE:    ;
          default: state <= FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             fetch_count_r <= '0;
    else if (counted_load) fetch_count_r <= fetch_count_r + 32'd1;
  end

  instruction_fetch_stage_if_id_register #(
    .BUBBLE (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .flush       (fif.flush_D),
    .stall       (fif.stall_D),
    .fetch_valid (state == FETCH),
    .instr_in    (fif.imem_rd),
    .pc_plus4_in (pc_f + PC_STEP),
    .instr       (instr_q),
    .pc_plus4    (pc_plus4_q),
    .valid       (valid_q)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;
  import instruction_fetch_stage_pkg::*;

  localparam logic [31:0] LAST_ADDR = 32'h0000_01FC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_stage_if fif ();

  instruction_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (128),
    .NOP_INSTR  (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (fif)
  );

  // ROM image: every word is distinct and never equal to the bubble.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hC000_0000 | (a >> 2);
  endfunction

  assign fif.imem_rd = rom_word(fif.imem_addr);

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // tail counts unstalled edges since the last ROM word was fetched:
  // 0 = still fetching, 1 = one bubble pending, 2 = program finished.
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_mis;
  int          m_tail;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_count = 32'h0;
    m_valid = 1'b0; m_mis = 1'b0; m_tail = 0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    if (fif.flush_D) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!fif.stall_D) begin
      if (m_tail == 0) begin
        m_instr = rom_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        m_count = m_count + 32'd1;
      end else begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end
    end
    m_mis = fif.pc_src_E && (fif.pc_target_E % 4 != 0);
    if (fif.pc_src_E) begin
      tgt    = fif.pc_target_E - (fif.pc_target_E % 4);
      m_pc   = tgt;
      m_tail = (tgt > LAST_ADDR) ? 2 : 0;
    end else if (!fif.stall_F) begin
      if (m_tail == 0) begin
        if (m_pc == LAST_ADDR) m_tail = 1;
        else                   m_pc = m_pc + 32'd4;
      end else if (m_tail == 1) begin
        m_tail = 2;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_pc"},    fif.imem_addr,           m_pc);
    check({tag, "_instr"}, fif.instr_D,             m_instr);
    check({tag, "_pc4"},   fif.pc_plus4_D,          m_pc4);
    check({tag, "_valid"}, 32'(fif.valid_D),        32'(m_valid));
    check({tag, "_mis"},   32'(fif.misalign),       32'(m_mis));
    check({tag, "_done"},  32'(fif.done),           32'(m_tail >= 2));
    check({tag, "_count"}, fif.fetch_count,         m_count);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic sf, input logic sd, input logic fl,
                       input logic ps, input logic [31:0] tgt);
    fif.stall_F = sf; fif.stall_D = sd; fif.flush_D = fl;
    fif.pc_src_E = ps; fif.pc_target_E = tgt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"},    fif.imem_addr,      32'h0);
    check({tag, "_instr"}, fif.instr_D,        32'h0);
    check({tag, "_pc4"},   fif.pc_plus4_D,     32'h0);
    check({tag, "_valid"}, 32'(fif.valid_D),   32'h0);
    check({tag, "_mis"},   32'(fif.misalign),  32'h0);
    check({tag, "_done"},  32'(fif.done),      32'h0);
    check({tag, "_count"}, fif.fetch_count,    32'h0);
    check({tag, "_state"}, 32'(fif.state),     32'(FETCH));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        sf, sd, fl, ps;
    logic [31:0] tgt;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_valid, e_mis, e_done;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t v(input logic sf, input logic sd, input logic fl,
                             input logic ps, input logic [31:0] tgt,
                             input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid,
                             input logic mis, input logic done,
                             input logic [31:0] cnt);
    vec_t r;
    r.sf = sf; r.sd = sd; r.fl = fl; r.ps = ps; r.tgt = tgt;
    r.e_pc = pc; r.e_instr = instr; r.e_pc4 = pc4;
    r.e_valid = valid; r.e_mis = mis; r.e_done = done; r.e_cnt = cnt;
    return r;
  endfunction

  initial begin
    // sequential fetch, then 3-cycle stall at 0x10
    tbl[0]  = v(0,0,0,0,0,     32'h04,  rom_word(32'h00),  32'h04,  1,0,0, 1);
    tbl[1]  = v(0,0,0,0,0,     32'h08,  rom_word(32'h04),  32'h08,  1,0,0, 2);
    tbl[2]  = v(0,0,0,0,0,     32'h0C,  rom_word(32'h08),  32'h0C,  1,0,0, 3);
    tbl[3]  = v(0,0,0,0,0,     32'h10,  rom_word(32'h0C),  32'h10,  1,0,0, 4);
    tbl[4]  = v(1,1,0,0,0,     32'h10,  rom_word(32'h0C),  32'h10,  1,0,0, 4);
    tbl[5]  = v(1,1,0,0,0,     32'h10,  rom_word(32'h0C),  32'h10,  1,0,0, 4);
    tbl[6]  = v(1,1,0,0,0,     32'h10,  rom_word(32'h0C),  32'h10,  1,0,0, 4);
    tbl[7]  = v(0,0,0,0,0,     32'h14,  rom_word(32'h10),  32'h14,  1,0,0, 5);
    // redirect with flush, then misaligned redirect without flush
    tbl[8]  = v(0,0,1,1,32'h40, 32'h40, 32'h0,             32'h0,   0,0,0, 5);
    tbl[9]  = v(0,0,0,0,0,     32'h44,  rom_word(32'h40),  32'h44,  1,0,0, 6);
    tbl[10] = v(0,0,0,1,32'h42, 32'h40, rom_word(32'h44),  32'h48,  1,1,0, 7);
    tbl[11] = v(0,0,0,0,0,     32'h44,  rom_word(32'h40),  32'h44,  1,0,0, 8);
    // flush beats stall_D
    tbl[12] = v(0,1,1,0,0,     32'h48,  32'h0,             32'h0,   0,0,0, 8);
    // jump to last word, LAST, DONE, hold
    tbl[13] = v(0,0,1,1,32'h1FC,32'h1FC,32'h0,             32'h0,   0,0,0, 8);
    tbl[14] = v(0,0,0,0,0,     32'h1FC, rom_word(32'h1FC), 32'h200, 1,0,0, 9);
    tbl[15] = v(0,0,0,0,0,     32'h1FC, 32'h0,             32'h0,   0,0,1, 9);
    tbl[16] = v(0,0,0,0,0,     32'h1FC, 32'h0,             32'h0,   0,0,1, 9);
    // redirect beyond ROM under stall_F, then back into range
    tbl[17] = v(1,0,0,1,32'h300,32'h300,32'h0,             32'h0,   0,0,1, 9);
    tbl[18] = v(0,0,0,1,32'h08, 32'h08, 32'h0,             32'h0,   0,0,0, 9);
    tbl[19] = v(0,0,0,0,0,     32'h0C,  rom_word(32'h08),  32'h0C,  1,0,0, 10);
  end

  // ---------------- main sequence ----------------
  initial begin
    drive(0, 0, 0, 0, 32'h0);
    reset = 1'b1;
    #1;
    check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // directed table
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].sf, tbl[i].sd, tbl[i].fl, tbl[i].ps, tbl[i].tgt);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_pc", i),    fif.imem_addr,        tbl[i].e_pc);
      check($sformatf("vec%0d_instr", i), fif.instr_D,          tbl[i].e_instr);
      check($sformatf("vec%0d_pc4", i),   fif.pc_plus4_D,       tbl[i].e_pc4);
      check($sformatf("vec%0d_valid", i), 32'(fif.valid_D),     32'(tbl[i].e_valid));
      check($sformatf("vec%0d_mis", i),   32'(fif.misalign),    32'(tbl[i].e_mis));
      check($sformatf("vec%0d_done", i),  32'(fif.done),        32'(tbl[i].e_done));
      check($sformatf("vec%0d_count", i), fif.fetch_count,      tbl[i].e_cnt);
      @(negedge clk);
    end

    // full program run from reset: every ROM word exactly once, in order
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(rom_word(32'(i * 4)));
    for (int c = 0; c < 140; c++) begin
      drive(0, 0, 0, 0, 32'h0);
      model_step();
      @(posedge clk);
      #1;
      compare_model("run");
      if (fif.valid_D) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL run_extra_fetch: got %h expected no further fetch", fif.instr_D);
        end else begin
          check("run_order", fif.instr_D, exp_q.pop_front());
        end
      end
      @(negedge clk);
    end
    check("run_queue_left", 32'(exp_q.size()), 32'h0);
    check("run_done",       32'(fif.done),     32'h1);
    check("run_final_pc",   fif.imem_addr,     LAST_ADDR);
    check("run_final_cnt",  fif.fetch_count,   32'd128);

    // randomized stimulus against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        sf, sd, fl, ps;
      logic [31:0] tgt;
      sf  = ($urandom_range(0, 9) < 2);
      sd  = ($urandom_range(0, 9) < 2);
      fl  = ($urandom_range(0, 9) == 0);
      ps  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(32'h1C0, 32'h210))
                                        : 32'($urandom_range(0, 32'h200));
      drive(sf, sd, fl, ps, tgt);
      model_step();
      @(posedge clk);
      #1;
      compare_model("rand");
      @(negedge clk);
    end

    // asynchronous reset in the middle of a stall
    drive(1, 1, 0, 0, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("areset_stall");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // asynchronous reset while a misaligned redirect is being reported
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 0, 32'h0);
      @(negedge clk);
    end
    drive(0, 0, 0, 1, 32'h0000_0062);
    @(posedge clk);
    #1;
    check("redir_mis_pulse", 32'(fif.misalign), 32'h1);
    check("redir_pc",        fif.imem_addr,     32'h60);
    #1;
    reset = 1'b1;
    #1;
    check_reset_values("areset_redir");
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // hard time bound so the run always terminates
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time bound");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
